// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg
//   Shared definitions for the unified memory port arbiter.
//   owner_e : identifies which master owns an in-flight read
//             (OWN_NONE / OWN_M0 / OWN_M1). The core's debug and trace logic
//             also uses this encoding.
//   LAST_M0 / LAST_M1 : encoding of the one-bit "previous grant owner" state.
// ---------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_e;

    localparam logic LAST_M0 = 1'b0;
    localparam logic LAST_M1 = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_arb.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
//   Pure combinational decision logic for two requesters. It holds no state:
//   the previous owner and the lock qualification are supplied by the parent.
//   Ports:
//     req0, req1 : requests from master 0 / master 1
//     last       : owner of the previous grant (LAST_M0 / LAST_M1)
//     lock_hold  : master 1 keeps ownership under contention
//     gnt0, gnt1 : one-hot grant, both low when nothing is requested
// ---------------------------------------------------------------------------
module rr_arbiter2
    import mem_port_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    input  logic lock_hold,
    output logic gnt0,
    output logic gnt1
);

    // Master 1 wins when it is the only requester, when it holds a burst
    // lock, or when master 0 owned the previous grant (round-robin).
    // Master 0 takes every remaining request, so the grant is never two-hot.
    always_comb begin
        gnt1 = req1 && (!req0 || lock_hold || (last == LAST_M0));
        gnt0 = req0 && !gnt1;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares the single unified memory port between the core (master 0) and a
//   program loader / DMA engine (master 1). One owner is granted per cycle,
//   its address phase is forwarded to memory, and the one-cycle-latency read
//   data is routed back to whichever master issued the read.
//   Ports:
//     clk, reset            : clock, synchronous active-high reset
//     mX_req/we/addr/wdata  : request, write enable, address, write data
//     m1_lock               : master 1 asks for back-to-back ownership
//     mX_gnt                : address phase accepted this cycle (combinational)
//     mX_rvalid / mX_rdata  : read return, one cycle after the grant
//     mem_en/we/addr/wdata  : muxed memory address phase
//     mem_rdata             : memory read data, one cycle after a read
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LOCK_MAX   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    input  logic                  m1_lock,
    output logic                  m0_gnt,
    output logic                  m1_gnt,
    output logic                  m0_rvalid,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] LOCK_LIMIT = CNT_W'(LOCK_MAX);

    logic             last;
    owner_e           rd_owner;
    logic [CNT_W-1:0] lock_cnt;
    logic             lock_hold;

    // The lock only applies once master 1 has actually won a contended
    // grant (lock_cnt > 0). `last` resets to M1, so without the nonzero
    // test a locked request at reset exit would starve master 0.
    always_comb begin
        lock_hold = m1_lock && (last == LAST_M1)
                    && (lock_cnt != '0) && (lock_cnt < LOCK_LIMIT);
    end

    rr_arbiter2 u_arb (
        .req0      (m0_req),
        .req1      (m1_req),
        .last      (last),
        .lock_hold (lock_hold),
        .gnt0      (m0_gnt),
        .gnt1      (m1_gnt)
    );

    // Forward the winner's address phase; drive zeros when idle so the
    // memory bus is quiet.
    always_comb begin
        mem_en    = m0_gnt || m1_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (m0_gnt) begin
            mem_we    = m0_we;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
        end else if (m1_gnt) begin
            mem_we    = m1_we;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
        end
    end

    // Read data is steered by the registered owner of the in-flight read and
    // forced to zero for the master that is not receiving data.
    always_comb begin
        m0_rvalid = (rd_owner == OWN_M0);
        m1_rvalid = (rd_owner == OWN_M1);
        m0_rdata  = m0_rvalid ? mem_rdata : '0;
        m1_rdata  = m1_rvalid ? mem_rdata : '0;
    end

    // Arbitration history, pending-read owner and burst-lock counter.
    // Reset drops any pending read; a write already issued stays done.
    always_ff @(posedge clk) begin
        if (reset) begin
            last     <= LAST_M1;
            rd_owner <= OWN_NONE;
            lock_cnt <= '0;
        end else begin
            if (mem_en) begin
                last <= m1_gnt ? LAST_M1 : LAST_M0;
            end

            if (m0_gnt && !m0_we) begin
                rd_owner <= OWN_M0;
            end else if (m1_gnt && !m1_we) begin
                rd_owner <= OWN_M1;
            end else begin
                rd_owner <= OWN_NONE;
            end

            if (!m1_lock || m0_gnt) begin
                lock_cnt <= '0;
            end else if (m1_gnt && m0_req && (lock_cnt < LOCK_LIMIT)) begin
                lock_cnt <= lock_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter (LOCK_MAX = 4). A small word memory
//   model sits on the memory port; it is preloaded with 0xA000_0000 + index
//   while reset is high so read data values are known in advance.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [0:63];

    int checks;
    int errors;

    mem_port_arbiter #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .LOCK_MAX   (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_lock   (m1_lock),
        .m0_gnt    (m0_gnt),
        .m1_gnt    (m1_gnt),
        .m0_rvalid (m0_rvalid),
        .m1_rvalid (m1_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_rdata  (m1_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory with one-cycle read latency; preloaded during reset.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) begin
                mem[i] <= 32'hA000_0000 + 32'(i);
            end
            mem_rdata <= '0;
        end else if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr[7:2]] <= mem_wdata;
            end else begin
                mem_rdata <= mem[mem_addr[7:2]];
            end
        end
    end

    // Counts a comparison and reports it when observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drives every master-side input at once.
    task automatic applyStimulus(input logic r0, input logic w0,
                                 input logic [31:0] a0, input logic [31:0] d0,
                                 input logic r1, input logic w1,
                                 input logic [31:0] a1, input logic [31:0] d1,
                                 input logic lk);
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
        m1_lock = lk;
    endtask

    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        stepClk();
        stepClk();
        reset = 1'b0;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, ".m0_gnt"},    32'(m0_gnt),    32'd0);
        checkOutput({tag, ".m1_gnt"},    32'(m1_gnt),    32'd0);
        checkOutput({tag, ".mem_en"},    32'(mem_en),    32'd0);
        checkOutput({tag, ".mem_we"},    32'(mem_we),    32'd0);
        checkOutput({tag, ".mem_addr"},  mem_addr,       32'd0);
        checkOutput({tag, ".mem_wdata"}, mem_wdata,      32'd0);
        checkOutput({tag, ".m0_rvalid"}, 32'(m0_rvalid), 32'd0);
        checkOutput({tag, ".m1_rvalid"}, 32'(m1_rvalid), 32'd0);
        checkOutput({tag, ".m0_rdata"},  m0_rdata,       32'd0);
        checkOutput({tag, ".m1_rdata"},  m1_rdata,       32'd0);
    endtask

    // Both masters read continuously (m0 at 0x04, m1 at 0x08); pat bit i is
    // 1 when master 1 must own cycle i. Read returns of the previous cycle
    // are checked alongside each grant.
    task automatic contend(input string tag, input logic lk, input int n,
                           input logic [15:0] pat);
        logic prevG1;
        logic expG1;
        prevG1 = 1'b0;
        for (int i = 0; i < n; i++) begin
            applyStimulus(1, 0, 32'h04, 0, 1, 0, 32'h08, 0, lk);
            #1;
            expG1 = pat[i];
            checkOutput($sformatf("%s.c%0d.m1_gnt", tag, i), 32'(m1_gnt), 32'(expG1));
            checkOutput($sformatf("%s.c%0d.m0_gnt", tag, i), 32'(m0_gnt), 32'(!expG1));
            checkOutput($sformatf("%s.c%0d.addr", tag, i), mem_addr,
                        expG1 ? 32'h08 : 32'h04);
            if (i > 0) begin
                checkOutput($sformatf("%s.c%0d.m1_rvalid", tag, i), 32'(m1_rvalid), 32'(prevG1));
                checkOutput($sformatf("%s.c%0d.m0_rvalid", tag, i), 32'(m0_rvalid), 32'(!prevG1));
                checkOutput($sformatf("%s.c%0d.rdata", tag, i),
                            prevG1 ? m1_rdata : m0_rdata,
                            prevG1 ? 32'hA000_0002 : 32'hA000_0001);
            end
            prevG1 = expG1;
            stepClk();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput({tag, ".tail_m1_rvalid"}, 32'(m1_rvalid), 32'(prevG1));
        checkOutput({tag, ".tail_m0_rvalid"}, 32'(m0_rvalid), 32'(!prevG1));
    endtask

    initial begin
        logic [15:0] rrPat;
        logic [15:0] lockPat;
        checks = 0;
        errors = 0;
        rrPat   = 16'b0000_0000_0000_1010;
        lockPat = 16'b0000_0011_1101_1110;

        $display("[TB] reset and idle state");
        doReset();
        #1;
        checkIdleOutputs("reset");

        $display("[TB] single master 0 read of 0x10");
        applyStimulus(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("rd10.m0_gnt", 32'(m0_gnt), 32'd1);
        checkOutput("rd10.m1_gnt", 32'(m1_gnt), 32'd0);
        checkOutput("rd10.mem_en", 32'(mem_en), 32'd1);
        checkOutput("rd10.mem_we", 32'(mem_we), 32'd0);
        checkOutput("rd10.addr",   mem_addr,    32'h10);
        stepClk();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("rd10.m0_rvalid", 32'(m0_rvalid), 32'd1);
        checkOutput("rd10.m0_rdata",  m0_rdata,       32'hA000_0004);
        checkOutput("rd10.m1_rvalid", 32'(m1_rvalid), 32'd0);
        checkOutput("rd10.m1_rdata",  m1_rdata,       32'd0);
        stepClk();

        $display("[TB] round-robin contention");
        doReset();
        contend("rr", 1'b0, 4, rrPat);
        stepClk();

        $display("[TB] locked contention");
        doReset();
        contend("lock", 1'b1, 10, lockPat);
        stepClk();

        $display("[TB] master 1 write then master 0 read-back");
        applyStimulus(0, 0, 0, 0, 1, 1, 32'h20, 32'hDEAD_BEEF, 0);
        #1;
        checkOutput("wr.m1_gnt", 32'(m1_gnt), 32'd1);
        checkOutput("wr.mem_we", 32'(mem_we), 32'd1);
        checkOutput("wr.addr",   mem_addr,    32'h20);
        checkOutput("wr.wdata",  mem_wdata,   32'hDEAD_BEEF);
        stepClk();
        applyStimulus(1, 0, 32'h20, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("rb.m0_gnt",    32'(m0_gnt),    32'd1);
        checkOutput("rb.mem_we",    32'(mem_we),    32'd0);
        checkOutput("rb.m1_rvalid", 32'(m1_rvalid), 32'd0);
        stepClk();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("rb.m0_rvalid", 32'(m0_rvalid), 32'd1);
        checkOutput("rb.m0_rdata",  m0_rdata,       32'hDEAD_BEEF);
        checkOutput("rb.m1_rvalid_after", 32'(m1_rvalid), 32'd0);
        stepClk();

        $display("[TB] reset while a master 1 read is pending");
        applyStimulus(0, 0, 0, 0, 1, 0, 32'h08, 0, 0);
        reset = 1'b1;
        #1;
        checkOutput("rst.m1_gnt", 32'(m1_gnt), 32'd1);
        stepClk();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("rst.m1_rvalid", 32'(m1_rvalid), 32'd0);
        checkOutput("rst.m1_rdata",  m1_rdata,       32'd0);
        reset = 1'b0;
        stepClk();
        checkIdleOutputs("postrst");

        $display("[TB] idle cycles keep arbitration history");
        applyStimulus(1, 0, 32'h04, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("hist.m0_gnt", 32'(m0_gnt), 32'd1);
        stepClk();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("hist.m0_rvalid", 32'(m0_rvalid), 32'd1);
        stepClk();
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("idle%0d.mem_en", i), 32'(mem_en), 32'd0);
            checkOutput($sformatf("idle%0d.mem_we", i), 32'(mem_we), 32'd0);
            checkOutput($sformatf("idle%0d.rvalid", i), 32'({m0_rvalid, m1_rvalid}), 32'd0);
            stepClk();
        end
        applyStimulus(1, 0, 32'h04, 0, 1, 0, 32'h08, 0, 0);
        #1;
        checkOutput("hist.m1_gnt", 32'(m1_gnt), 32'd1);
        checkOutput("hist.m0_gnt_low", 32'(m0_gnt), 32'd0);
        stepClk();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("hist.m1_rdata", m1_rdata, 32'hA000_0002);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-master arbiter sharing the multicycle core's single unified memory port between the core (master 0, fetch and load/store traffic selected by I_or_D) and a program loader / DMA engine (master 1). It decides one owner per cycle, forwards the owner's address phase to the memory, and routes the one-cycle-latency read data back to the correct master. It sits between the core datapath's memory interface and the memory/GPIO-mapped storage. The core's control unit stalls on a deasserted grant.

## Interface
- DATA_WIDTH, 32, data bus width
- ADDR_WIDTH, 32, byte address width
- LOCK_MAX, 16, max consecutive locked grants to master 1 while master 0 waits (≥1)

- clk  in  1  clock; all state on rising edge
- reset  in  1  synchronous, active-high
- m0_req / m1_req  in  1  access request, held until granted
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  ADDR_WIDTH  access address
- m0_wdata / m1_wdata  in  DATA_WIDTH  write data
- m1_lock  in  1  master 1 requests back-to-back ownership (burst load)
- m0_gnt / m1_gnt  out  1  address phase accepted this cycle (combinational)
- m0_rvalid / m1_rvalid  out  1  read data valid (registered)
- m0_rdata / m1_rdata  out  DATA_WIDTH  read data (mem_rdata, masked to 0 when not valid)
- mem_en  out  1  memory access this cycle
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_WIDTH  muxed address
- mem_wdata  out  DATA_WIDTH  muxed write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid one cycle after a read with mem_en=1

## Operation
- State: `last` (owner of previous grant, 1 bit), `rd_owner` (encoding NONE/M0/M1, 2 bits), `lock_cnt` (clog2(LOCK_MAX+1) bits).
- Decision each cycle:
  - Only one req → that master wins.
  - Both req, m1_lock=1, last=M1, lock_cnt<LOCK_MAX → M1 wins.
  - Both req otherwise → round-robin: winner is the master ≠ `last`.
- Grant: exactly one of m0_gnt/m1_gnt high when any req is high; never both. mem_en = m0_gnt|m1_gnt. mem_we/addr/wdata come from the winner. When idle, mem_addr/wdata = 0 and mem_we = 0.
- `last` updates to the winner on any grant; it holds when idle.
- lock_cnt:
  - Increments (saturating at LOCK_MAX) on an M1 grant while m0_req=1 and m1_lock=1.
  - Clears on any M0 grant, or when m1_lock=0.
  - When it reaches LOCK_MAX with m0_req high, the next contention goes to M0.
- Read return: rd_owner ← winner if granted and we=0, else NONE. mX_rvalid = (rd_owner==MX), registered. rdata is routed by rd_owner.
- Writes produce no rvalid.
- A master may issue a new request in the same cycle its previous read returns. Back-to-back grants to either master are allowed every cycle.

## Timing
- Reset values:
  - gnt: 0 (combinational, follows req)
  - rvalid: 0
  - rd_owner: NONE
  - last: M1, so M0 wins the first contention
  - lock_cnt: 0
- Grant latency 0 cycles (same-cycle as req). Read latency 1 cycle from grant to rvalid.
- Reset asserted mid-read: the pending rvalid is dropped (rd_owner→NONE next edge). Memory write already issued is not undone.
- Simultaneous req with m1_lock=1 at reset exit: M0 wins (last=M1, cnt=0 → lock only applies once M1 has been last).
- LOCK_MAX=1: M1 receives at most one grant between M0 grants under contention.

## Structure
- Shared package: owner encoding constants OWN_NONE=2'd0, OWN_M0=2'd1, OWN_M1=2'd2; these are reused by the core's debug/trace logic.
- Sub-module rr_arbiter2: pure decision logic (reqs, last, lock condition → one-hot grant). Counters and registers stay in mem_port_arbiter.

## Test plan
- Reset then m0_req read addr 0x10 only → m0_gnt same cycle, mem_addr=0x10. Next cycle m0_rvalid=1 with m0_rdata=mem value; m1_rvalid stays 0.
- Both req continuously, m1_lock=0 → grants alternate M0,M1,M0,M1, starting with M0.
- Both req, m1_lock=1, LOCK_MAX=4 → sequence M0, then M1×4, then M0, then M1×4. lock_cnt never exceeds 4.
- M1 write 0xDEADBEEF to 0x20, then M0 read 0x20 next cycle → mem_we=1 on the first cycle; m0_rdata=0xDEADBEEF one cycle after the M0 grant; no m1_rvalid.
- Read granted to M1, reset asserted on the following edge → m1_rvalid=0 after reset, all outputs at reset values.
- No requests for 5 cycles → mem_en=0 and mem_we=0, last unchanged, no rvalid.
